acc_requant_relu: RTL and testbench

//  Downstream of the partial-sum accumulator: takes one row of DP accumulated 32-bit sums per beat,

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_requant_relu_fifo.sv | 49 ++++
 rtl/acc_requant_relu.sv | 152 +++++++++++++++
 tb/tb_acc_requant_relu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants and helpers for the accumulator and requant datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package acc_pkg;

  localparam int DW = 32;  // accumulated sum width, signed
  localparam int DP = 56;  // lanes (pixels) per row
  localparam int OW = 8;   // activation width, unsigned

  typedef logic [OW-1:0] act_t;

  // Extract lane idx from a packed row of DW-bit sums.
  function automatic logic [DW-1:0] lane_slice(input logic [DW*DP-1:0] row, input int unsigned idx);
    return row[DW*idx +: DW];
  endfunction

  // Clamp a non-negative wide value to the OW-bit unsigned range.
  function automatic act_t sat_u(input logic [DW+1:0] v);
    if (v > {{(DW+2-OW){1'b0}}, {OW{1'b1}}})
      return {OW{1'b1}};
    else
      return v[OW-1:0];
  endfunction

endpackage

// File: rtl/acc_requant_relu_fifo.sv
// Output row buffer: synchronous FIFO with full/empty/count flags, head shown combinationally.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: push is refused while full unless a pop happens on the same edge.
module rq_row_fifo #(
  parameter int W     = 449,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Storage array; contents are don't-care until written, empty gating hides them.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/acc_requant_relu.sv
// Bias add, ReLU and right-shift requant of DP-lane rows into a small output FIFO. Optional REQ_ROUND_EN: round-half-up.
// Latency: row accepted at edge t is in S1 at t, S2 at t+1, FIFO head after t+2.
// Backpressure: full FIFO stalls S2, then S1, then in_ready; out_ready reaches in_ready only through that chain.
module acc_requant_relu
  import acc_pkg::*;
#(
  parameter int SHW        = 5,
  parameter int ROWS       = 56,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW*DP-1:0]   in_data,
  input  logic [DW-1:0]      cfg_bias,
  input  logic [SHW-1:0]     cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OW*DP-1:0]   out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int RCW = $clog2(ROWS);
  localparam int SW  = DW + 1;              // bias-added sum width, never overflows
  localparam int FW  = OW*DP + 1;           // FIFO entry: {last, activations}
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  logic               rdy_q;
  logic [RCW-1:0]     row_cnt;
  logic [DW-1:0]      sh_bias;
  logic [SHW-1:0]     sh_shift;
  logic               row_first, in_fire;
  logic [DW-1:0]      bias_eff;
  logic [SHW-1:0]     shift_eff;

  logic               s1_v, s1_last;
  logic [SHW-1:0]     s1_shift;
  logic [SW*DP-1:0]   s1_sum, sum_row;
  logic               s2_v, s2_last;
  logic [OW*DP-1:0]   s2_act, q_row;
  logic               s1_adv, s2_free, push, pop;

  logic [FW-1:0]      head;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;

  // Row 0 of a map takes config straight from the ports; later rows use the copy latched then.
  assign row_first = (row_cnt == '0);
  assign bias_eff  = row_first ? cfg_bias  : sh_bias;
  assign shift_eff = row_first ? cfg_shift : sh_shift;

  assign pop      = !fifo_empty && out_ready;
  assign push     = s2_v && (!fifo_full || pop);
  assign s2_free  = !s2_v || push;
  assign s1_adv   = s1_v && s2_free;
  assign in_ready = rdy_q && (!s1_v || s1_adv);
  assign in_fire  = in_valid && in_ready;

  for (genvar i = 0; i < DP; i++) begin : g_lane
    logic [DW-1:0]   in_lane;
    logic [SW-1:0]   s_held;
    logic [DW+1:0]   mag;
    act_t            q_lane;

    assign in_lane = lane_slice(in_data, i);
    assign sum_row[SW*i +: SW] = {in_lane[DW-1], in_lane} + {bias_eff[DW-1], bias_eff};
    assign s_held = s1_sum[SW*i +: SW];

    // ReLU, shift and clamp of the S1 sum using the shift captured with that row.
    always_comb begin
      mag = {1'b0, s_held};
`ifdef REQ_ROUND_EN
      if (s1_shift != '0) mag = mag + ((DW+2)'(1) << (s1_shift - SHW'(1)));
`endif
      q_lane = sat_u(mag >> s1_shift);
      if (s_held[SW-1] || (32'(s1_shift) >= SW)) q_lane = '0;
    end

    assign q_row[OW*i +: OW] = q_lane;
  end

  // Input ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Row position within the map and the per-map config shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      sh_bias  <= '0;
      sh_shift <= '0;
    end else if (in_fire) begin
      row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RCW'(1);
      if (row_first) begin
        sh_bias  <= cfg_bias;
        sh_shift <= cfg_shift;
      end
    end
  end

  // Stage occupancy: a stage fills from upstream and empties when it hands off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (in_fire)     s1_v <= 1'b1;
      else if (s1_adv) s1_v <= 1'b0;
      if (s1_adv)      s2_v <= 1'b1;
      else if (push)   s2_v <= 1'b0;
    end
  end

  // Stage payloads; qualified by the valid bits so they need no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sum   <= sum_row;
      s1_last  <= (row_cnt == LAST_ROW);
      s1_shift <= shift_eff;
    end
    if (s1_adv) begin
      s2_act  <= q_row;
      s2_last <= s1_last;
    end
  end

  rq_row_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({s2_last, s2_act}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[OW*DP-1:0] : '0;
  assign out_last  = out_valid && head[FW-1];
  assign busy      = s1_v || s2_v || (fifo_count != '0);

endmodule

// File: tb/tb_acc_requant_relu.sv
// Bench for acc_requant_relu: vector table plus hand-written stall/stream/reset sequences.
// Expected rows go to a scoreboard queue on acceptance and are compared at the output handshake.
// Define REQ_ROUND_EN for the rounding build.
module tb_acc_requant_relu;
  import acc_pkg::*;

  localparam int SHW = 5;
  localparam int ROWS = 56;
  localparam int FD = 4;
`ifdef REQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic               clk, rst_n;
  logic               in_valid, in_ready;
  logic [DW*DP-1:0]   in_data;
  logic [DW-1:0]      cfg_bias;
  logic [SHW-1:0]     cfg_shift;
  logic               out_valid, out_ready, out_last, busy;
  logic [OW*DP-1:0]   out_data;

  acc_requant_relu #(.SHW(SHW), .ROWS(ROWS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  typedef struct { logic [OW*DP-1:0] d; logic last; } exp_t;
  typedef struct {
    logic [31:0] a, b, bias;
    logic [4:0]  sh;
    logic [7:0]  ea, eb;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [OW*DP-1:0] act, input logic [OW*DP-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Independent reference for one lane.
  function automatic logic [7:0] exp_lane(input longint v, input int sh);
    longint q;
    if (v < 0) return 8'd0;
    if (RND && sh > 0) q = (v + (longint'(1) << (sh - 1))) >>> sh;
    else               q = v >>> sh;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic logic [DW*DP-1:0] mk2(input logic [31:0] a, input logic [31:0] b);
    logic [DW*DP-1:0] r;
    for (int i = 0; i < DP; i++) r[DW*i +: DW] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [OW*DP-1:0] mk2o(input logic [7:0] a, input logic [7:0] b);
    logic [OW*DP-1:0] r;
    for (int i = 0; i < DP; i++) r[OW*i +: OW] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [DW*DP-1:0] mk_seq(input int r);
    logic [DW*DP-1:0] d;
    for (int i = 0; i < DP; i++) d[DW*i +: DW] = 32'(r * 3 + i);
    return d;
  endfunction

  function automatic logic [OW*DP-1:0] exp_seq(input int r, input int bias, input int sh);
    logic [OW*DP-1:0] o;
    for (int i = 0; i < DP; i++) o[OW*i +: OW] = exp_lane(longint'(r * 3 + i + bias), sh);
    return o;
  endfunction

  // Output monitor: a handshake on the next edge is visible at this negedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got row %0h, required no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("row_data", out_data, mon_e.d);
        chk("row_last", {447'd0, out_last}, {447'd0, mon_e.last});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_row(input logic [DW*DP-1:0] d, input logic [OW*DP-1:0] ed, input logic el);
    int n = 0;
    exp_t e;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, required 1", n);
    end else begin
      e.d = ed;
      e.last = el;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", OW*DP'(sb.size()), '0);
    @(negedge clk);
    chk("busy_idle", {447'd0, busy}, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int unsigned t0;

    vt[0] = '{32'd100, 32'd100, -32'sd20, 5'd2, 8'd20, 8'd20};
    vt[1] = '{32'd10, 32'h7FFF_FFFF, -32'sd15, 5'd0, 8'd0, 8'd255};
    vt[2] = '{32'd6, 32'd5, 32'd0, 5'd2, RND ? 8'd2 : 8'd1, 8'd1};
    vt[3] = '{-32'sd100, 32'd1000, 32'd50, 5'd3, 8'd0, 8'd131};
    vt[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd31, 8'd0, RND ? 8'd2 : 8'd1};
    vt[5] = '{32'd1019, 32'd0, 32'd0, 5'd2, RND ? 8'd255 : 8'd254, 8'd0};
    vt[6] = '{32'd509, 32'd3, 32'd0, 5'd1, RND ? 8'd255 : 8'd254, RND ? 8'd2 : 8'd1};
    vt[7] = '{32'h0001_2345, 32'h0001_8000, 32'd0, 5'd16, 8'd1, RND ? 8'd2 : 8'd1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_bias = '0;
    cfg_shift = '0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", {447'd0, in_ready}, '0);
    chk("rst_out_valid", {447'd0, out_valid}, '0);
    chk("rst_busy", {447'd0, busy}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", {447'd0, out_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First row latency straight out of reset
    cfg_bias = -32'sd20;
    cfg_shift = 5'd2;
    send_row(mk2(32'd100, 32'd100), mk2o(8'd20, 8'd20), 1'b0);
    @(negedge clk);
    chk("lat_s1_out_valid", {447'd0, out_valid}, '0);
    chk("lat_s1_busy", {447'd0, busy}, {447'd0, 1'b1});
    @(negedge clk);
    chk("lat_s2_out_valid", {447'd0, out_valid}, '0);
    @(negedge clk);
    chk("lat_fifo_out_valid", {447'd0, out_valid}, {447'd0, 1'b1});
    @(negedge clk);
    chk("lat_busy_fall", {447'd0, busy}, '0);
    @(posedge clk); #1;

    // Arithmetic vectors, each as row 0 of a fresh map
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cfg_bias = vt[v].bias;
      cfg_shift = vt[v].sh;
      send_row(mk2(vt[v].a, vt[v].b), mk2o(vt[v].ea, vt[v].eb), 1'b0);
      wait_drain();
    end

    // Full map stream, mid-map config change ignored, next map picks up new config
    do_reset();
    @(posedge clk); #1;
    t0 = cyc;
    for (int r = 0; r < 59; r++) begin
      if (r == 0)  begin cfg_bias = 32'd0;     cfg_shift = 5'd0; end
      if (r == 10) begin cfg_bias = 32'd100;   cfg_shift = 5'd1; end
      if (r == 56) begin cfg_bias = 32'd5;     cfg_shift = 5'd0; end
      if (r == 57) begin cfg_bias = -32'sd50;  cfg_shift = 5'd3; end
      send_row(mk_seq(r), exp_seq(r, (r < 56) ? 0 : 5, 0), r == 55);
    end
    chk("stream_cycles", OW*DP'(cyc - t0), OW*DP'(59));
    wait_drain();

    // Stalled consumer: exactly FIFO_DEPTH+2 rows fit, then release with more traffic
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    cfg_bias = 32'd0;
    cfg_shift = 5'd0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      in_data = mk_seq(k);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp_seq(k, 0, 0), 1'b0});
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stall_accepted", OW*DP'(k), OW*DP'(FD + 2));
    @(negedge clk);
    chk("stall_in_ready", {447'd0, in_ready}, '0);
    chk("stall_out_valid", {447'd0, out_valid}, {447'd0, 1'b1});
    chk("stall_head", out_data, sb[0].d);
    @(negedge clk);
    chk("stall_head_stable", out_data, sb[0].d);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int r = k; r < k + 4; r++) send_row(mk_seq(r), exp_seq(r, 0, 0), 1'b0);
    wait_drain();

    // Reset with rows in flight: everything discarded, counter and config restart
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    cfg_bias = 32'd7;
    cfg_shift = 5'd0;
    for (int r = 0; r < 3; r++) send_row(mk_seq(r), exp_seq(r, 7, 0), 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", {447'd0, out_valid}, '0);
    chk("midrst_busy", {447'd0, busy}, '0);
    chk("midrst_in_ready", {447'd0, in_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cfg_bias = -32'sd3;
    send_row(mk_seq(10), exp_seq(10, -3, 0), 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
